// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sequencer sharing one floating-point adder
// among N_REQ requesters. Operands and results pass through untouched; the
// block only arbitrates, launches the adder, waits for done or a timeout and
// returns a tagged response.
`timescale 1ns/1ps
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 clock_100kHz,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_op_a,
    input  logic [32*N_REQ-1:0]  req_op_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 add_start,
    output logic [31:0]          add_op_a,
    output logic [31:0]          add_op_b,
    input  logic                 add_done,
    input  logic [31:0]          add_result,
    input  logic [3:0]           add_status,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic [3:0]           rsp_status,
    input  logic                 rsp_ready,
    output logic                 timeout_flag
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int                SUM_W    = ID_W + 1;
    localparam int                TMR_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [SUM_W-1:0]  N_WIDE   = SUM_W'(N_REQ);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [TMR_W-1:0]    r_timer;
    logic                r_add_start;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic [3:0]          r_rsp_status;
    logic                r_timeout_flag;

    logic                w_grant_any;
    logic [ID_W-1:0]     w_grant_id;
    logic [SUM_W-1:0]    w_sum;
    logic [ID_W-1:0]     w_idx;
    logic [31:0]         w_op_a;
    logic [31:0]         w_op_b;
    logic                w_accept;
    logic                w_done_hit;
    logic                w_tmo_hit;
    logic                w_rsp_acc;

    // Round-robin search from r_ptr; scanning downwards lets the lowest
    // offset (highest priority) requester be the last, winning, write.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum       = {1'b0, r_ptr} + SUM_W'(k);
            w_idx       = (w_sum >= N_WIDE) ? ID_W'(w_sum - N_WIDE) : ID_W'(w_sum);
            w_grant_id  = req_valid[w_idx] ? w_idx : w_grant_id;
            w_grant_any = w_grant_any | req_valid[w_idx];
        end
    end

    // Select the winning requester's operand pair.
    always_comb begin
        w_op_a = 32'h0000_0000;
        w_op_b = 32'h0000_0000;
        for (int k = 0; k < N_REQ; k++) begin
            w_op_a = (w_grant_id == ID_W'(k)) ? req_op_a[32*k +: 32] : w_op_a;
            w_op_b = (w_grant_id == ID_W'(k)) ? req_op_b[32*k +: 32] : w_op_b;
        end
    end

    assign w_accept   = (r_state == S_IDLE) & w_grant_any;
    assign w_done_hit = (r_state == S_WAIT) & add_done;
    assign w_tmo_hit  = (r_state == S_WAIT) & ~add_done & (r_timer == TMR_LAST);
    assign w_rsp_acc  = (r_state == S_RESP) & rsp_ready;

    // req_ready is a combinational strobe; forced low while reset is held so
    // every output reads zero during reset.
    assign req_ready = (w_accept && !reset) ? (N_REQ'(1) << w_grant_id) : '0;

    // Next-state logic: done beats timeout when both land in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (add_done || (r_timer == TMR_LAST)) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture grant id and operands; launch pulse is one cycle after grant.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            r_add_start <= 1'b0;
            r_id        <= '0;
            r_op_a      <= 32'h0000_0000;
            r_op_b      <= 32'h0000_0000;
        end else begin
            r_add_start <= w_accept;
            if (w_accept) begin
                r_id   <= w_grant_id;
                r_op_a <= w_op_a;
                r_op_b <= w_op_b;
            end
        end
    end

    // Wait timer: cleared in ISSUE, counts in WAIT, saturates so it never wraps.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == S_ISSUE) begin
            r_timer <= '0;
        end else if ((r_state == S_WAIT) && (r_timer != TMR_LAST)) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Response registers, sticky timeout flag and fairness pointer.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= 32'h0000_0000;
            r_rsp_status   <= 4'h0;
            r_timeout_flag <= 1'b0;
            r_ptr          <= '0;
        end else if (w_done_hit) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= add_result;
            r_rsp_status <= add_status;
        end else if (w_tmo_hit) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_data     <= 32'h0000_0000;
            r_rsp_status   <= 4'hF;
            r_timeout_flag <= 1'b1;
        end else if (w_rsp_acc) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_id == ID_LAST) ? '0 : r_id + ID_W'(1);
        end
    end

    assign add_start    = r_add_start;
    assign add_op_a     = r_op_a;
    assign add_op_b     = r_op_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_status   = r_rsp_status;
    assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: a driver predicts the round-robin
// winner and pushes the expected response; a monitor pops and compares on
// every response; a behavioural adder answers add_start after a chosen latency.
`timescale 1ns/1ps
module tb_fp_add_arbiter;

    localparam int N     = 4;
    localparam int TO    = 8;
    localparam int NEVER = 99;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [32*N-1:0]  req_op_a;
    logic [32*N-1:0]  req_op_b;
    logic [N-1:0]     req_ready;
    logic             add_start;
    logic [31:0]      add_op_a;
    logic [31:0]      add_op_b;
    logic             add_done;
    logic [31:0]      add_result;
    logic [3:0]       add_status;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [31:0]      rsp_data;
    logic [3:0]       rsp_status;
    logic             rsp_ready;
    logic             timeout_flag;

    logic             model_done;
    logic             spur_done;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [3:0]  st;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          issued  = 0;
    int          retired = 0;
    int          model_ptr = 0;
    logic        exp_tflag = 1'b0;
    int          t_grant = 0;
    int          rst_epoch = 0;
    int          add_lat = 1;
    logic [31:0] add_res_v = 32'h0;
    logic [3:0]  add_st_v = 4'h0;
    logic [31:0] exp_oa = 32'h0;
    logic [31:0] exp_ob = 32'h0;
    int          bp_next = 0;

    assign add_done = model_done | spur_done;

    fp_add_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clock_100kHz (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .req_ready    (req_ready),
        .add_start    (add_start),
        .add_op_a     (add_op_a),
        .add_op_b     (add_op_b),
        .add_done     (add_done),
        .add_result   (add_result),
        .add_status   (add_status),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .rsp_ready    (rsp_ready),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first requester with valid set, scanning from p.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"},    req_ready,    0);
        chk({tag, "_add_start"},    add_start,    0);
        chk({tag, "_add_op_a"},     add_op_a,     0);
        chk({tag, "_add_op_b"},     add_op_b,     0);
        chk({tag, "_rsp_valid"},    rsp_valid,    0);
        chk({tag, "_rsp_id"},       rsp_id,       0);
        chk({tag, "_rsp_data"},     rsp_data,     0);
        chk({tag, "_rsp_status"},   rsp_status,   0);
        chk({tag, "_timeout_flag"}, timeout_flag, 0);
    endtask

    // Present a request set, wait for the grant, push the expected response.
    task automatic issue_txn(input logic [N-1:0] mask, input logic fixed,
                             input logic [31:0] fa, input logic [31:0] fb,
                             input int lat, input logic [31:0] res,
                             input logic [3:0] st, input int bp);
        int          w;
        logic        granted;
        logic        tmo;
        logic [N-1:0] oh;
        logic [31:0] a_v [N];
        logic [31:0] b_v [N];
        exp_t        e;
        w = pick(mask, model_ptr);
        for (int i = 0; i < N; i++) begin
            a_v[i] = fixed ? fa : $urandom;
            b_v[i] = fixed ? fb : $urandom;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_op_a[32*i +: 32] = a_v[i];
            req_op_b[32*i +: 32] = b_v[i];
        end
        exp_oa    = a_v[w];
        exp_ob    = b_v[w];
        add_lat   = lat;
        add_res_v = res;
        add_st_v  = st;
        bp_next   = bp;
        req_valid = mask;
        #1;
        granted = 1'b0;
        for (int g = 0; g < 20; g++) begin
            if (req_ready != '0) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!granted) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_wait: no req_ready within 20 cycles, required one-hot %0d", w);
            req_valid = '0;
            return;
        end
        t_grant = cyc;
        oh = '0;
        oh[w] = 1'b1;
        chk("grant_onehot", req_ready, oh);
        tmo   = (lat > TO);
        e.id   = w;
        e.data = tmo ? 32'h0 : res;
        e.st   = tmo ? 4'hF : st;
        e.cyc  = tmo ? (t_grant + 2 + TO) : (t_grant + 2 + lat);
        exp_q.push_back(e);
        exp_tflag = exp_tflag | tmo;
        model_ptr = (w + 1) % N;
        issued++;
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic wait_retire();
        for (int c = 0; c < 300; c++) begin
            if (retired == issued) break;
            @(negedge clk);
        end
        chk("all_retired", retired, issued);
        chk("timeout_flag", timeout_flag, exp_tflag);
    endtask

    task automatic rand_txn(input logic [N-1:0] mask, input int bp);
        int r;
        int lat;
        r = $urandom_range(0, 9);
        if (r == 0)      lat = NEVER;
        else if (r == 1) lat = TO;
        else             lat = $urandom_range(1, TO - 1);
        issue_txn(mask, 1'b0, 32'h0, 32'h0, lat, $urandom, 4'($urandom_range(0, 3)), bp);
        wait_retire();
    endtask

    // Behavioural adder: answers each add_start after add_lat cycles, or never.
    initial begin
        int          lat;
        int          ep;
        logic [31:0] cap_a;
        logic [31:0] cap_b;
        model_done = 1'b0;
        add_result = 32'h0;
        add_status = 4'h0;
        forever begin
            @(negedge clk);
            if (add_start === 1'b1) begin
                chk("start_cycle", cyc, t_grant + 1);
                chk("start_op_a", add_op_a, exp_oa);
                chk("start_op_b", add_op_b, exp_ob);
                cap_a = add_op_a;
                cap_b = add_op_b;
                lat   = add_lat;
                ep    = rst_epoch;
                @(negedge clk);
                chk("start_one_cycle", add_start, 0);
                if (lat <= TO) begin
                    repeat (lat - 1) @(negedge clk);
                    if (ep == rst_epoch) begin
                        chk("op_a_stable", add_op_a, cap_a);
                        chk("op_b_stable", add_op_b, cap_b);
                    end
                    model_done = 1'b1;
                    add_result = add_res_v;
                    add_status = add_st_v;
                    @(negedge clk);
                    model_done = 1'b0;
                    add_result = $urandom;
                    add_status = 4'h0;
                end
            end
        end
    end

    // Monitor: pop and compare each response, apply back-pressure, check hold.
    initial begin
        exp_t        e;
        int          bp;
        logic [1:0]  h_id;
        logic [31:0] h_data;
        logic [3:0]  h_st;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: id %0d data %0h status %0h, required no response", rsp_id, rsp_data, rsp_status);
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_status", rsp_status, e.st);
                    chk("rsp_cycle", cyc, e.cyc);
                    bp     = (bp_next >= 0) ? bp_next : $urandom_range(0, 3);
                    h_id   = rsp_id;
                    h_data = rsp_data;
                    h_st   = rsp_status;
                    rsp_ready = 1'b0;
                    for (int i = 0; i < bp; i++) begin
                        @(negedge clk);
                        chk("hold_valid", rsp_valid, 1);
                        chk("hold_id", rsp_id, h_id);
                        chk("hold_data", rsp_data, h_data);
                        chk("hold_status", rsp_status, h_st);
                        chk("bp_req_ready", req_ready, 0);
                        chk("bp_no_start", add_start, 0);
                    end
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    chk("rsp_drop", rsp_valid, 0);
                    retired++;
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_op_a  = '0;
        req_op_b  = '0;
        spur_done = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request, adder answers 3 cycles after start.
        issue_txn(4'b0001, 1'b1, 32'h3E00_0000, 32'h3E00_0000, 3, 32'h4000_0000, 4'h0, 0);
        wait_retire();

        // Done coinciding with the last timer cycle: real result, no flag.
        issue_txn(4'($urandom_range(1, 15)), 1'b0, 32'h0, 32'h0, TO, $urandom, 4'h1, 0);
        wait_retire();

        // Spurious done while idle.
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_idle_rsp", rsp_valid, 0);
        chk("spur_idle_start", add_start, 0);

        // Round-robin with every requester pending.
        for (int i = 0; i < 6; i++) begin
            issue_txn(4'b1111, 1'b0, 32'h0, 32'h0, $urandom_range(1, TO - 1), $urandom, 4'($urandom_range(0, 3)), 0);
            wait_retire();
        end

        // Back-pressure for five cycles.
        issue_txn(4'($urandom_range(1, 15)), 1'b0, 32'h0, 32'h0, 2, $urandom, 4'h3, 5);
        wait_retire();

        // Timeout: adder never answers.
        issue_txn(4'($urandom_range(1, 15)), 1'b0, 32'h0, 32'h0, NEVER, 32'h0, 4'h0, 0);
        wait_retire();

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            rand_txn(4'($urandom_range(1, 15)), -1);
        end

        // Mid-WAIT reset: serve requester 2 first so the pointer sits at 3.
        issue_txn(4'b0100, 1'b0, 32'h0, 32'h0, 2, $urandom, 4'h0, 0);
        wait_retire();
        issue_txn(4'b0001, 1'b0, 32'h0, 32'h0, 6, $urandom, 4'h2, 0);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        req_valid = 4'b1111;
        rst_epoch++;
        #1;
        check_all_zero("midwait_reset");
        exp_q.delete();
        issued    = retired;
        model_ptr = 0;
        exp_tflag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        repeat (8) @(negedge clk);
        chk("stale_done_rsp", rsp_valid, 0);
        chk("stale_done_flag", timeout_flag, 0);
        issue_txn(4'b1100, 1'b0, 32'h0, 32'h0, 3, $urandom, 4'h1, 0);
        wait_retire();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
